verificador_pista_param: RTL and testbench

Parametrised track-sequence checker for the robot-track exercise. Accepts one digit per rising edge of `insere`, compares it against an N-digit expected track, tracks position and error count, and reports the outcome on an error LED, a success LED and a seven-segment display. Successor to the fixed 6-digit checker: adds configurable length and digit width, an error budget, distinct total and partial success, and an optional run-time programmable track.

---
 rtl/verificador_pista_param.sv | 202 ++++++++++++++++++++
 tb/tb_verificador_pista_param.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_pista_param.sv
// verificador_pista_param: parametrised robot-track sequence checker.
// Takes one digit per rising edge of insere and compares it with an
// N_DIGITS-long track. It counts mismatches against an error budget and
// reports the result on two LEDs and a seven-segment display.
// Optional feature macro: PISTA_PROG_EN. When it is defined, the track can be
// loaded at run time while the checker is idle, using carrega=1.
`timescale 1ns/1ps

module verificador_pista_param #(
    parameter int N_DIGITS  = 6,
    parameter int DIGIT_W   = 4,
    parameter int MAX_ERROS = 3,
    parameter logic [N_DIGITS*DIGIT_W-1:0] PISTA = 24'h590060
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 numero,
    input  logic                               insere,
    input  logic                               carrega,
    output logic                               ledErro,
    output logic                               ledSucesso,
    output logic [6:0]                         display,
    output logic [3:0]                         posicao,
    output logic [$clog2(MAX_ERROS+1)-1:0]     erros,
    output logic [2:0]                         estado
);

    localparam int EW = $clog2(MAX_ERROS+1);

    localparam logic [2:0] INICIAL         = 3'd0;
    localparam logic [2:0] VERIFICACAO     = 3'd1;
    localparam logic [2:0] SUCESSO_TOTAL   = 3'd2;
    localparam logic [2:0] SUCESSO_PARCIAL = 3'd3;
    localparam logic [2:0] FALHA           = 3'd4;

    localparam logic [3:0]    ULTIMA   = 4'(N_DIGITS - 1);
    localparam logic [EW-1:0] LIMITE   = EW'(MAX_ERROS);

    logic [2:0]         estado_q, estado_d;
    logic [3:0]         posicao_q, posicao_d;
    logic [EW-1:0]      erros_q, erros_d;
    logic               ledErro_q, ledErro_d;
    logic               insere_q;

    logic               evento;
    logic               avaliar;
    logic [EW-1:0]      errosMais;
    logic [DIGIT_W-1:0] digitoEsperado;
    logic [DIGIT_W-1:0] trackDigits [N_DIGITS];

    assign evento    = insere & ~insere_q;
    assign errosMais = erros_q + EW'(1);

`ifdef PISTA_PROG_EN
    logic [DIGIT_W-1:0] track_q [N_DIGITS];
    logic [DIGIT_W-1:0] track_d [N_DIGITS];
    logic [3:0]         ptr_q, ptr_d;

    // Programmable track storage and write pointer, reloaded from PISTA on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                track_q[i] <= PISTA[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
            ptr_q <= 4'd0;
        end else begin
            track_q <= track_d;
            ptr_q   <= ptr_d;
        end
    end

    // Track digits come from the register array when programming is enabled.
    always_comb begin
        trackDigits = track_q;
    end
`else
    logic unusedCarrega;
    assign unusedCarrega = carrega;

    // Without programming, digit i is the i-th field of PISTA, MSB first.
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            trackDigits[i] = PISTA[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
        end
    end
`endif

    // Select the digit expected at the current position.
    always_comb begin
        digitoEsperado = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (posicao_q == 4'(i)) begin
                digitoEsperado = trackDigits[i];
            end
        end
    end

    // Next-state logic: program, evaluate a digit, or ignore the event.
    always_comb begin
        estado_d  = estado_q;
        posicao_d = posicao_q;
        erros_d   = erros_q;
        ledErro_d = ledErro_q;
        avaliar   = 1'b0;
`ifdef PISTA_PROG_EN
        track_d   = track_q;
        ptr_d     = ptr_q;
`endif
        case (estado_q)
            INICIAL: begin
                if (evento) begin
`ifdef PISTA_PROG_EN
                    if (carrega) begin
                        for (int i = 0; i < N_DIGITS; i++) begin
                            if (ptr_q == 4'(i)) begin
                                track_d[i] = numero;
                            end
                        end
                        ptr_d = (ptr_q == ULTIMA) ? 4'd0 : ptr_q + 4'd1;
                    end else begin
                        avaliar = 1'b1;
                    end
`else
                    avaliar = 1'b1;
`endif
                end
            end
            VERIFICACAO: begin
                if (evento) begin
                    avaliar = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (avaliar) begin
            if (numero == digitoEsperado) begin
                posicao_d = posicao_q + 4'd1;
                ledErro_d = 1'b0;
                if (posicao_q == ULTIMA) begin
                    estado_d = (erros_q == '0) ? SUCESSO_TOTAL : SUCESSO_PARCIAL;
                end else begin
                    estado_d = VERIFICACAO;
                end
            end else begin
                erros_d   = errosMais;
                ledErro_d = 1'b1;
                estado_d  = (errosMais == LIMITE) ? FALHA : VERIFICACAO;
            end
        end
    end

    // Main state registers and the delayed copy of insere used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            posicao_q <= 4'd0;
            erros_q   <= '0;
            ledErro_q <= 1'b0;
            insere_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            posicao_q <= posicao_d;
            erros_q   <= erros_d;
            ledErro_q <= ledErro_d;
            insere_q  <= insere;
        end
    end

    // Seven-segment decode from registered state; segments are {g,f,e,d,c,b,a}.
    always_comb begin
        display = 7'b1000000;
        case (estado_q)
            VERIFICACAO: begin
                case (posicao_q)
                    4'd0:    display = 7'b0111111;
                    4'd1:    display = 7'b0000110;
                    4'd2:    display = 7'b1011011;
                    4'd3:    display = 7'b1001111;
                    4'd4:    display = 7'b1100110;
                    4'd5:    display = 7'b1101101;
                    4'd6:    display = 7'b1111101;
                    4'd7:    display = 7'b0000111;
                    4'd8:    display = 7'b1111111;
                    default: display = 7'b1000000;
                endcase
            end
            SUCESSO_TOTAL:   display = 7'b1101101;
            SUCESSO_PARCIAL: display = 7'b1110011;
            FALHA:           display = 7'b1110001;
            default:         display = 7'b1000000;
        endcase
    end

    assign ledErro    = ledErro_q;
    assign ledSucesso = (estado_q == SUCESSO_TOTAL) || (estado_q == SUCESSO_PARCIAL);
    assign posicao    = posicao_q;
    assign erros      = erros_q;
    assign estado     = estado_q;

endmodule

// File: tb/tb_verificador_pista_param.sv
// Self-checking bench for verificador_pista_param: a reference model feeds a
// scoreboard that is compared once per digit event, plus directed checks.
`timescale 1ns/1ps

module tb_verificador_pista_param;

    localparam int N    = 6;
    localparam int MAXE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] numero, numeroB;
    logic       insere, insereB, carrega, carregaB;

    logic       ledErro, ledSucesso, ledErroB, ledSucessoB;
    logic [6:0] display, displayB;
    logic [3:0] posicao, posicaoB;
    logic [1:0] erros, errosB;
    logic [2:0] estado, estadoB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         dutB;
        logic [2:0] estado;
        logic [3:0] posicao;
        logic [1:0] erros;
        logic       ledErro;
        logic       ledSucesso;
        logic [6:0] display;
        string      tag;
    } expT;

    expT scoreboard[$];

    int         mEstado, mPos, mErros, mPtr;
    bit         mLed;
    logic [3:0] mTrack [N];
    bit         progEn;

    verificador_pista_param dut (
        .clk(clk), .reset(reset), .numero(numero), .insere(insere), .carrega(carrega),
        .ledErro(ledErro), .ledSucesso(ledSucesso), .display(display),
        .posicao(posicao), .erros(erros), .estado(estado)
    );

    verificador_pista_param #(.N_DIGITS(1), .DIGIT_W(4), .MAX_ERROS(3), .PISTA(4'h7)) dutB (
        .clk(clk), .reset(reset), .numero(numeroB), .insere(insereB), .carrega(carregaB),
        .ledErro(ledErroB), .ledSucesso(ledSucessoB), .display(displayB),
        .posicao(posicaoB), .erros(errosB), .estado(estadoB)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dispFor(int est, int pos);
        case (est)
            0: return 7'b1000000;
            1: begin
                case (pos)
                    0: return 7'b0111111;
                    1: return 7'b0000110;
                    2: return 7'b1011011;
                    3: return 7'b1001111;
                    4: return 7'b1100110;
                    5: return 7'b1101101;
                    6: return 7'b1111101;
                    7: return 7'b0000111;
                    8: return 7'b1111111;
                    default: return 7'b1000000;
                endcase
            end
            2: return 7'b1101101;
            3: return 7'b1110011;
            4: return 7'b1110001;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic void modelReset();
        mEstado = 0; mPos = 0; mErros = 0; mPtr = 0; mLed = 1'b0;
        mTrack  = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
    endfunction

    function automatic void modelEvent(logic [3:0] num, bit car);
        if (mEstado == 0 && car && progEn) begin
            mTrack[mPtr] = num;
            mPtr = (mPtr + 1) % N;
        end else if (mEstado == 0 || mEstado == 1) begin
            if (num == mTrack[mPos]) begin
                mPos = mPos + 1;
                mLed = 1'b0;
                mEstado = (mPos == N) ? ((mErros == 0) ? 2 : 3) : 1;
            end else begin
                mErros = mErros + 1;
                mLed = 1'b1;
                mEstado = (mErros == MAXE) ? 4 : 1;
            end
        end
    endfunction

    function automatic expT modelSnapshot(string tag);
        expT e;
        e.dutB       = 1'b0;
        e.estado     = 3'(mEstado);
        e.posicao    = 4'(mPos);
        e.erros      = 2'(mErros);
        e.ledErro    = mLed;
        e.ledSucesso = (mEstado == 2 || mEstado == 3);
        e.display    = dispFor(mEstado, mPos);
        e.tag        = tag;
        return e;
    endfunction

    // Scoreboard monitor: one expectation is consumed per negedge after an event.
    always @(negedge clk) begin : monitor
        expT         e;
        logic [17:0] act;
        logic [17:0] exv;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            if (e.dutB)
                act = {estadoB, posicaoB, errosB, ledErroB, ledSucessoB, displayB};
            else
                act = {estado, posicao, erros, ledErro, ledSucesso, display};
            exv = {e.estado, e.posicao, e.erros, e.ledErro, e.ledSucesso, e.display};
            checks++;
            if (act !== exv) begin
                errors++;
                $display("[TB] FAIL sb_%s got {est,pos,err,le,ls,disp}=%b expected %b", e.tag, act, exv);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] num, input bit car, input string tag);
        @(negedge clk);
        numero = num; carrega = car; insere = 1'b1;
        @(posedge clk);
        modelEvent(num, car);
        scoreboard.push_back(modelSnapshot(tag));
        @(negedge clk);
        insere = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulusB(input logic [3:0] num, input expT e);
        @(negedge clk);
        numeroB = num; insereB = 1'b1;
        @(posedge clk);
        scoreboard.push_back(e);
        @(negedge clk);
        insereB = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({estado, posicao, erros, ledErro, ledSucesso, display} !== {3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 7'b1000000}) begin
            errors++;
            $display("[TB] FAIL reset_values got %b expected %b",
                     {estado, posicao, erros, ledErro, ledSucesso, display}, {3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 7'b1000000});
        end
        doReset();
        checks++;
        if ({estadoB, posicaoB, errosB, displayB} !== {3'd0, 4'd0, 2'd0, 7'b1000000}) begin
            errors++;
            $display("[TB] FAIL reset_values_b got %b expected %b",
                     {estadoB, posicaoB, errosB, displayB}, {3'd0, 4'd0, 2'd0, 7'b1000000});
        end
    endtask

    task automatic test_total();
        logic [3:0] seq [6] = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd6, 4'd0};
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(seq[i], 1'b0, "total");
        checks++;
        if ({estado, display, ledSucesso, erros, ledErro, posicao} !== {3'd2, 7'b1101101, 1'b1, 2'd0, 1'b0, 4'd6}) begin
            errors++;
            $display("[TB] FAIL total_final got %b expected %b",
                     {estado, display, ledSucesso, erros, ledErro, posicao}, {3'd2, 7'b1101101, 1'b1, 2'd0, 1'b0, 4'd6});
        end
    endtask

    task automatic test_partial();
        logic [3:0] rest [4] = '{4'd0, 4'd0, 4'd6, 4'd0};
        doReset();
        applyStimulus(4'd5, 1'b0, "partial");
        applyStimulus(4'd3, 1'b0, "partial");
        checks++;
        if ({ledErro, erros, posicao} !== {1'b1, 2'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL partial_after_wrong got %b expected %b", {ledErro, erros, posicao}, {1'b1, 2'd1, 4'd1});
        end
        applyStimulus(4'd9, 1'b0, "partial");
        checks++;
        if (ledErro !== 1'b0) begin
            errors++;
            $display("[TB] FAIL partial_led_clear got %b expected 0", ledErro);
        end
        for (int i = 0; i < 4; i++) applyStimulus(rest[i], 1'b0, "partial");
        checks++;
        if ({estado, display, ledSucesso} !== {3'd3, 7'b1110011, 1'b1}) begin
            errors++;
            $display("[TB] FAIL partial_final got %b expected %b", {estado, display, ledSucesso}, {3'd3, 7'b1110011, 1'b1});
        end
    endtask

    task automatic test_failure();
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(4'd7, 1'b0, "failure");
        checks++;
        if ({erros, estado, ledErro, display} !== {2'd3, 3'd4, 1'b1, 7'b1110001}) begin
            errors++;
            $display("[TB] FAIL failure_state got %b expected %b", {erros, estado, ledErro, display}, {2'd3, 3'd4, 1'b1, 7'b1110001});
        end
        applyStimulus(4'd5, 1'b0, "fail_ignore");
        checks++;
        if ({erros, estado, posicao, ledErro} !== {2'd3, 3'd4, 4'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL failure_terminal got %b expected %b", {erros, estado, posicao, ledErro}, {2'd3, 3'd4, 4'd0, 1'b1});
        end
    endtask

    task automatic test_hold_and_reset();
        doReset();
        @(negedge clk);
        numero = 4'd5; carrega = 1'b0; insere = 1'b1;
        @(posedge clk);
        modelEvent(4'd5, 1'b0);
        scoreboard.push_back(modelSnapshot("hold"));
        repeat (10) @(negedge clk);
        checks++;
        if ({posicao, estado, erros} !== {4'd1, 3'd1, 2'd0}) begin
            errors++;
            $display("[TB] FAIL hold_single_event got %b expected %b", {posicao, estado, erros}, {4'd1, 3'd1, 2'd0});
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({estado, posicao, erros, ledErro, ledSucesso, display} !== {3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 7'b1000000}) begin
            errors++;
            $display("[TB] FAIL async_reset got %b expected %b",
                     {estado, posicao, erros, ledErro, ledSucesso, display}, {3'd0, 4'd0, 2'd0, 1'b0, 1'b0, 7'b1000000});
        end
        insere = 1'b0;
        @(negedge clk);
        insere = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({estado, posicao} !== {3'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL event_during_reset got %b expected %b", {estado, posicao}, {3'd0, 4'd0});
        end
        @(negedge clk);
        insere = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
    endtask

    task automatic test_program();
        logic [2:0] expEstado;
        doReset();
        for (int d = 1; d <= 6; d++) applyStimulus(4'(d), 1'b1, "prog_load");
        for (int d = 1; d <= 6; d++) applyStimulus(4'(d), 1'b0, "prog_run");
`ifdef PISTA_PROG_EN
        expEstado = 3'd2;
`else
        expEstado = 3'd4;
`endif
        checks++;
        if (estado !== expEstado) begin
            errors++;
            $display("[TB] FAIL program_final got %0d expected %0d", estado, expEstado);
        end
    endtask

    task automatic test_random();
        logic [3:0] num;
        for (int run = 0; run < 4; run++) begin
            doReset();
            for (int k = 0; k < 14; k++) begin
                if ($urandom_range(0, 2) == 0 || mPos >= N)
                    num = 4'($urandom_range(0, 15));
                else
                    num = mTrack[mPos];
                applyStimulus(num, 1'b0, "random");
            end
        end
    endtask

    task automatic test_single_digit();
        expT e;
        doReset();
        e = '{dutB: 1'b1, estado: 3'd2, posicao: 4'd1, erros: 2'd0, ledErro: 1'b0,
              ledSucesso: 1'b1, display: 7'b1101101, tag: "n1_total"};
        applyStimulusB(4'd7, e);
        checks++;
        if ({estadoB, posicaoB} !== {3'd2, 4'd1}) begin
            errors++;
            $display("[TB] FAIL n1_total got %b expected %b", {estadoB, posicaoB}, {3'd2, 4'd1});
        end
        doReset();
        e = '{dutB: 1'b1, estado: 3'd1, posicao: 4'd0, erros: 2'd1, ledErro: 1'b1,
              ledSucesso: 1'b0, display: 7'b0111111, tag: "n1_wrong"};
        applyStimulusB(4'd3, e);
        e = '{dutB: 1'b1, estado: 3'd3, posicao: 4'd1, erros: 2'd1, ledErro: 1'b0,
              ledSucesso: 1'b1, display: 7'b1110011, tag: "n1_partial"};
        applyStimulusB(4'd7, e);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog timeout expected completion before 200000ns");
        $fatal(1, "[TB] timeout");
    end

    initial begin
`ifdef PISTA_PROG_EN
        progEn = 1'b1;
`else
        progEn = 1'b0;
`endif
        numero = '0; numeroB = '0; insere = 1'b0; insereB = 1'b0;
        carrega = 1'b0; carregaB = 1'b0;
        modelReset();
        test_reset();
        test_total();
        test_partial();
        test_failure();
        test_hold_and_reset();
        test_program();
        test_random();
        test_single_digit();
        repeat (3) @(negedge clk);
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
